// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control decoder: opcodes, functs, ALU codes, ctrol bit positions.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_W    = 4;
    localparam int unsigned CTRL_W   = 8;
    localparam int unsigned WORD_W   = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_BLEZ  = 6'h06;
    localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'h07;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_LUI  = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1100;

    localparam int unsigned CTRL_REGDST   = 7;
    localparam int unsigned CTRL_ALUSRC   = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_REGWRITE = 4;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_BRANCH   = 1;
    localparam int unsigned CTRL_JUMP     = 0;

endpackage

// File: rtl/mips_alu_ctrl.sv
// Combinational ALU operation select from opcode/funct; unknown encodings give 0.
module mips_alu_ctrl
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_W-1:0]    alu_op_c
);

    always_comb begin
        alu_op_c = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_JR: alu_op_c = ALU_ADD;
                    FN_SUB, FN_SUBU:        alu_op_c = ALU_SUB;
                    FN_AND:                 alu_op_c = ALU_AND;
                    FN_OR:                  alu_op_c = ALU_OR;
                    FN_XOR:                 alu_op_c = ALU_XOR;
                    FN_NOR:                 alu_op_c = ALU_NOR;
                    FN_SLL:                 alu_op_c = ALU_SLL;
                    FN_SRL:                 alu_op_c = ALU_SRL;
                    FN_SRA:                 alu_op_c = ALU_SRA;
                    FN_SLT:                 alu_op_c = ALU_SLT;
                    FN_SLTU:                alu_op_c = ALU_SLTU;
                    default:                alu_op_c = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_J, OP_JAL: alu_op_c = ALU_ADD;
            OP_SLTI:                                       alu_op_c = ALU_SLT;
            OP_SLTIU:                                      alu_op_c = ALU_SLTU;
            OP_ANDI:                                       alu_op_c = ALU_AND;
            OP_ORI:                                        alu_op_c = ALU_OR;
            OP_XORI:                                       alu_op_c = ALU_XOR;
            OP_LUI:                                        alu_op_c = ALU_LUI;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:              alu_op_c = ALU_SUB;
            default:                                       alu_op_c = '0;
        endcase
    end

endmodule

// File: rtl/mips_decoder.sv
// Main control decoder: control vector, branch resolution and SLT writeback, all registered.
module mips_decoder
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                equalrsrt,
    input  logic                rsmaior,
    input  logic                rsmrt,
    output logic [CTRL_W-1:0]   ctrol,
    output logic [ALU_W-1:0]    outsaida,
    output logic [WORD_W-1:0]   rt,
    output logic                slt_mux
);

    localparam logic [CTRL_W-1:0] CTRL_RTYPE = 8'b1001_0000;
    localparam logic [CTRL_W-1:0] CTRL_IMM   = 8'b0101_0000;
    localparam logic [CTRL_W-1:0] CTRL_LW    = 8'b0111_1000;
    localparam logic [CTRL_W-1:0] CTRL_SW    = 8'b0100_0100;
    localparam logic [CTRL_W-1:0] CTRL_J     = 8'b0000_0001;
    localparam logic [CTRL_W-1:0] CTRL_JAL   = 8'b0001_0001;

    logic [ALU_W-1:0]  alu_op_c;
    logic [CTRL_W-1:0] ctrl_c;
    logic              slt_sel_c;
    logic              slt_flag_c;

    mips_alu_ctrl u_alu_ctrl (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op_c (alu_op_c)
    );

    // Main decode; slt_flag_c is only meaningful when slt_sel_c is set
    always_comb begin
        ctrl_c     = '0;
        slt_sel_c  = 1'b0;
        slt_flag_c = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLL, FN_SRL, FN_SRA: ctrl_c = CTRL_RTYPE;
                    FN_SLT, FN_SLTU: begin
                        ctrl_c     = CTRL_RTYPE;
                        slt_sel_c  = 1'b1;
                        slt_flag_c = rsmrt;
                    end
                    FN_JR:   ctrl_c = CTRL_J;
                    default: ctrl_c = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ctrl_c = CTRL_IMM;
            OP_SLTI, OP_SLTIU: begin
                ctrl_c     = CTRL_IMM;
                slt_sel_c  = 1'b1;
                slt_flag_c = rsmrt;
            end
            OP_LW:   ctrl_c = CTRL_LW;
            OP_SW:   ctrl_c = CTRL_SW;
            OP_BEQ:  ctrl_c[CTRL_BRANCH] = equalrsrt;
            OP_BNE:  ctrl_c[CTRL_BRANCH] = ~equalrsrt;
            OP_BLEZ: ctrl_c[CTRL_BRANCH] = ~rsmaior;
            OP_BGTZ: ctrl_c[CTRL_BRANCH] = rsmaior;
            OP_J:    ctrl_c = CTRL_J;
            OP_JAL:  ctrl_c = CTRL_JAL;
            default: ctrl_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrol    <= '0;
            outsaida <= '0;
            rt       <= '0;
            slt_mux  <= 1'b0;
        end else begin
            ctrol    <= ctrl_c;
            outsaida <= alu_op_c;
            rt       <= {{(WORD_W-1){1'b0}}, slt_flag_c};
            slt_mux  <= slt_sel_c;
        end
    end

endmodule

// File: tb/tb_mips_decoder.sv
// Directed-vector bench for mips_decoder with hand-computed expected outputs.
module tb_mips_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        equalrsrt;
    logic        rsmaior;
    logic        rsmrt;
    logic [7:0]  ctrol;
    logic [3:0]  outsaida;
    logic [31:0] rt;
    logic        slt_mux;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mips_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .equalrsrt (equalrsrt),
        .rsmaior   (rsmaior),
        .rsmrt     (rsmrt),
        .ctrol     (ctrol),
        .outsaida  (outsaida),
        .rt        (rt),
        .slt_mux   (slt_mux)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] e_ctrl, input logic [3:0] e_alu,
                             input logic [31:0] e_rt, input logic e_mux);
        check({tag, ".ctrol"},    32'(ctrol),    32'(e_ctrl));
        check({tag, ".outsaida"}, 32'(outsaida), 32'(e_alu));
        check({tag, ".rt"},       rt,            e_rt);
        check({tag, ".slt_mux"},  32'(slt_mux),  32'(e_mux));
    endtask

    // Drive between edges, sample 1 time unit after the capturing edge
    task automatic apply(input logic [5:0] op, input logic [5:0] fn,
                         input logic eq, input logic ma, input logic mr);
        @(negedge clk);
        opcode = op; funct = fn; equalrsrt = eq; rsmaior = ma; rsmrt = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        opcode = 6'h23; funct = 6'h00; equalrsrt = 1'b0; rsmaior = 1'b0; rsmrt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_out("reset", 8'h00, 4'h0, 32'd0, 1'b0);
        @(posedge clk); #1;
        check_out("reset_held", 8'h00, 4'h0, 32'd0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("lw_after_reset", 8'b0111_1000, 4'b0010, 32'd0, 1'b0);

        apply(6'h00, 6'h20, 1'b1, 1'b1, 1'b1); check_out("add",   8'b1001_0000, 4'b0010, 32'd0, 1'b0);
        apply(6'h00, 6'h23, 1'b0, 1'b0, 1'b0); check_out("subu",  8'b1001_0000, 4'b0110, 32'd0, 1'b0);
        apply(6'h00, 6'h27, 1'b0, 1'b0, 1'b0); check_out("nor",   8'b1001_0000, 4'b1100, 32'd0, 1'b0);
        apply(6'h00, 6'h03, 1'b0, 1'b0, 1'b0); check_out("sra",   8'b1001_0000, 4'b1001, 32'd0, 1'b0);
        apply(6'h00, 6'h2A, 1'b0, 1'b0, 1'b1); check_out("slt",   8'b1001_0000, 4'b0111, 32'd1, 1'b1);
        apply(6'h00, 6'h2B, 1'b0, 1'b0, 1'b0); check_out("sltu",  8'b1001_0000, 4'b1000, 32'd0, 1'b1);
        apply(6'h00, 6'h08, 1'b0, 1'b0, 1'b0); check_out("jr",    8'b0000_0001, 4'b0010, 32'd0, 1'b0);
        apply(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0); check_out("sw",    8'b0100_0100, 4'b0010, 32'd0, 1'b0);
        apply(6'h04, 6'h00, 1'b1, 1'b0, 1'b0); check_out("beq_t", 8'b0000_0010, 4'b0110, 32'd0, 1'b0);
        apply(6'h04, 6'h00, 1'b0, 1'b0, 1'b0); check_out("beq_n", 8'b0000_0000, 4'b0110, 32'd0, 1'b0);
        apply(6'h05, 6'h00, 1'b1, 1'b0, 1'b0); check_out("bne_n", 8'b0000_0000, 4'b0110, 32'd0, 1'b0);
        apply(6'h05, 6'h00, 1'b0, 1'b0, 1'b0); check_out("bne_t", 8'b0000_0010, 4'b0110, 32'd0, 1'b0);
        apply(6'h06, 6'h00, 1'b0, 1'b0, 1'b0); check_out("blez_t", 8'b0000_0010, 4'b0110, 32'd0, 1'b0);
        apply(6'h07, 6'h00, 1'b0, 1'b0, 1'b0); check_out("bgtz_n", 8'b0000_0000, 4'b0110, 32'd0, 1'b0);
        apply(6'h07, 6'h00, 1'b0, 1'b1, 1'b0); check_out("bgtz_t", 8'b0000_0010, 4'b0110, 32'd0, 1'b0);
        apply(6'h0A, 6'h00, 1'b0, 1'b1, 1'b0); check_out("slti_0", 8'b0101_0000, 4'b0111, 32'd0, 1'b1);
        apply(6'h0A, 6'h00, 1'b0, 1'b1, 1'b1); check_out("slti_1", 8'b0101_0000, 4'b0111, 32'd1, 1'b1);
        apply(6'h0B, 6'h00, 1'b0, 1'b0, 1'b1); check_out("sltiu", 8'b0101_0000, 4'b1000, 32'd1, 1'b1);
        apply(6'h0E, 6'h00, 1'b1, 1'b1, 1'b1); check_out("xori",  8'b0101_0000, 4'b0011, 32'd0, 1'b0);
        apply(6'h0F, 6'h00, 1'b0, 1'b0, 1'b0); check_out("lui",   8'b0101_0000, 4'b1010, 32'd0, 1'b0);
        apply(6'h09, 6'h00, 1'b0, 1'b0, 1'b0); check_out("addiu", 8'b0101_0000, 4'b0010, 32'd0, 1'b0);
        apply(6'h02, 6'h00, 1'b0, 1'b0, 1'b0); check_out("j",     8'b0000_0001, 4'b0010, 32'd0, 1'b0);
        apply(6'h03, 6'h00, 1'b0, 1'b0, 1'b0); check_out("jal",   8'b0001_0001, 4'b0010, 32'd0, 1'b0);
        apply(6'h3F, 6'h00, 1'b1, 1'b1, 1'b1); check_out("bad_op", 8'h00, 4'h0, 32'd0, 1'b0);
        apply(6'h00, 6'h3F, 1'b1, 1'b1, 1'b1); check_out("bad_fn", 8'h00, 4'h0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of an SLT decode clears outputs before any edge
        apply(6'h0A, 6'h00, 1'b0, 1'b0, 1'b1); check_out("pre_rst", 8'b0101_0000, 4'b0111, 32'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("mid_rst", 8'h00, 4'h0, 32'd0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("post_rst", 8'b0101_0000, 4'b0111, 32'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_decoder.md
# mips_decoder

Main control and ALU-control decoder for the single-issue MIPS core; module name `mips_decoder`. It sits between the instruction fetch/register-read stage and the execute/memory/writeback datapath. From `opcode`/`funct` and three comparator flags it produces:
- an 8-bit main control vector,
- a 4-bit ALU operation code,
- the resolved branch decision,
- the set-less-than result word with its writeback-mux select.

All outputs are registered.

## Interface
No parameters.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  instruction [31:26]
- `funct`  in  6  instruction [5:0], used only when `opcode`=0
- `equalrsrt`  in  1  rs == rt (datapath comparator)
- `rsmaior`  in  1  rs > 0, signed (for BLEZ/BGTZ)
- `rsmrt`  in  1  rs < second operand (rt or imm), signedness set by the datapath per instruction
- `ctrol`  out  8  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchTaken, Jump}, bit 7 first
- `outsaida`  out  4  ALU operation code
- `rt`  out  32  SLT result, {31'b0, flag}
- `slt_mux`  out  1  1 = writeback takes `rt` instead of ALU/memory result

## Operation
ALU codes:
- AND 0000, OR 0001, ADD 0010, XOR 0011
- SLL 0100, SRL 0101, SUB 0110, SLT 0111
- SLTU 1000, SRA 1001, LUI 1010, NOR 1100

R-type (`opcode`=0), `ctrol`=1001_0000 except JR:
- `funct` 0x20/0x21 → ADD; 0x22/0x23 → SUB
- 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
- 0x00 SLL, 0x02 SRL, 0x03 SRA
- 0x2A SLT, 0x2B SLTU: `slt_mux`=1, `rt`={31'b0,`rsmrt`}
- 0x08 JR: `ctrol`=0000_0001, ALU ADD
- any other funct: all outputs 0

I-type/J-type:
- 0x08/0x09 ADDI/ADDIU: 0101_0000, ADD
- 0x0A SLTI: 0101_0000, SLT, `slt_mux`=1, `rt`={31'b0,`rsmrt`}
- 0x0B SLTIU: same as SLTI but ALU code SLTU
- 0x0C ANDI / 0x0D ORI / 0x0E XORI: 0101_0000, AND/OR/XOR
- 0x0F LUI: 0101_0000, LUI
- 0x23 LW: 0111_1000, ADD
- 0x2B SW: 0100_0100, ADD
- Branches, all `ctrol`=0000_00B0, ALU SUB, with B =
  - 0x04 BEQ: `equalrsrt`
  - 0x05 BNE: !`equalrsrt`
  - 0x06 BLEZ: !`rsmaior`
  - 0x07 BGTZ: `rsmaior`
- 0x02 J: 0000_0001, ADD
- 0x03 JAL: 0001_0001, ADD
- unlisted opcode: all outputs 0 (NOP)

Output defaults:
- `rt`=0 and `slt_mux`=0 for every non-SLT instruction.
- Comparator flags are ignored outside branches and SLT.

## Timing
- Decode is combinational; all outputs come from flops updated on rising `clk`.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `rst_n` low asynchronously forces every output to 0 (NOP). Reset release takes effect at the next rising edge.
- Reset asserted mid-operation drops the pending decode; there is no other state.
- Flag changes alone (same opcode) update `ctrol[1]`/`rt` at the next edge.

## Structure
- Shared package `mips_pkg`: opcode constants, funct constants, ALU-code constants, `ctrol` bit-index constants.
- One natural sub-module `mips_alu_ctrl`: combinational `funct`/`opcode` → ALU code. Main decode and output registers stay in the top module.

## Test plan
- Reset: `rst_n`=0 with `opcode`=0x23 → all outputs 0. Release, one edge → `ctrol`=0111_1000, `outsaida`=0010.
- ADD: `opcode`=0, `funct`=0x20 → `ctrol`=1001_0000, `outsaida`=0010, `slt_mux`=0.
- SW: `opcode`=0x2B → `ctrol`=0100_0100, `outsaida`=0010.
- BEQ: `opcode`=4, `equalrsrt`=1 → `ctrol`=0000_0010, `outsaida`=0110. With `equalrsrt`=0 → 0000_0000. BNE gives the opposite result.
- SLTI: `opcode`=10, `rsmaior`=1, `rsmrt`=0 → `ctrol`=0101_0000, `outsaida`=0111, `slt_mux`=1, `rt`=0. With `rsmrt`=1 → `rt`=1.
- Undefined encoding: `opcode`=0x3F, or `opcode`=0 with `funct`=0x3F → all outputs 0. Each case is checked one cycle after the inputs are applied.
